// File: rtl/led_matrix_scanner_if.sv
// Frame delivery channel into the LED matrix scanner: one whole generation per transfer.
// A transfer happens on a rising edge where frame_valid and frame_ready are both high.
interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic [ROWS*COLS-1:0] frame_in;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-scan driver for an LED matrix: double-buffered frames, swapped only at frame boundaries.
// Outputs are registered with the FSM (no extra stage); frame_ready is low while a frame is pending.
module led_matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  frame_if,
  output logic [ROWS-1:0]      rows_out,
  output logic [COLS-1:0]      columns_out,
  output logic                 frame_done
);

  localparam int N    = ROWS * COLS;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(ROWS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [N-1:0]    active_q, active_d;
  logic [N-1:0]    shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [COLS-1:0] cols_q, cols_d;

  logic            accept;
  logic            boundary;

  assign accept = frame_if.frame_valid && ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    rows_d    = '0;
    cols_d    = '0;

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (row_q == ROW_LAST) begin
            row_d    = '0;
            boundary = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Swap and accept can never coincide: accept needs ready, which implies nothing pending.
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = frame_if.frame_in;
      pending_d = 1'b1;
    end

    // The boundary edge always enters BLANK, so a row lit here never sees a same-edge swap.
    if (state_d == ST_SHOW) begin
      rows_d = ROWS'(1) << row_d;
      cols_d = active_q[int'(row_d) * COLS +: COLS];
    end
  end

  assign ready_d = !pending_d;
  assign done_d  = boundary;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      row_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
    end
  end

  assign frame_if.frame_ready = ready_q;
  assign rows_out             = rows_q;
  assign columns_out          = cols_q;
  assign frame_done           = done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: default 8x8 instance plus a 4x4 instance with
// longer blanking; every cycle's expected outputs are queued and checked by one monitor.
module tb_led_matrix_scanner;

  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
    logic       done;
    logic       rdy;
  } exp_t;

  localparam logic [63:0] FRM_A = 64'h0807_0605_0403_0201;
  localparam logic [63:0] FRM_B = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FRM_C = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] FRM_S = 64'h0000_0000_0000_8421;

  logic clk;
  logic rst1, rst2;

  led_matrix_scanner_if #(.ROWS(8), .COLS(8)) if1 ();
  led_matrix_scanner_if #(.ROWS(4), .COLS(4)) if2 ();

  logic [7:0] rows1, cols1;
  logic       done1;
  logic [3:0] rows2, cols2;
  logic       done2;

  led_matrix_scanner #(
    .ROWS(8), .COLS(8), .DWELL_CYCLES(4), .BLANK_CYCLES(1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst1),
    .frame_if    (if1.slave),
    .rows_out    (rows1),
    .columns_out (cols1),
    .frame_done  (done1)
  );

  led_matrix_scanner #(
    .ROWS(4), .COLS(4), .DWELL_CYCLES(2), .BLANK_CYCLES(2)
  ) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .frame_if    (if2.slave),
    .rows_out    (rows2),
    .columns_out (cols2),
    .frame_done  (done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q1[$];
  exp_t q2[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   end_req     = 1'b0;
  bit   end_ack     = 1'b0;

  // Expected scan outputs k edges after reset release; the reset cycle counts as blank phase 0.
  function automatic exp_t scan_exp(int k, int P, int B, int F, int C,
                                    logic [63:0] frm, logic rdy);
    exp_t e;
    int   q;
    int   r;
    logic [63:0] sh;
    e      = '0;
    q      = k % P;
    r      = (k % F) / P;
    if (q >= B) begin
      sh        = (frm >> (r * C)) & ((64'd1 << C) - 64'd1);
      e.rows[r] = 1'b1;
      e.cols    = sh[7:0];
    end
    e.done = (k % F == 0);
    e.rdy  = rdy;
    return e;
  endfunction

  task automatic drive1(input bit r, input bit v, input logic [63:0] d, input exp_t e);
    @(negedge clk);
    rst1            = r;
    if1.frame_valid = v;
    if1.frame_in    = d;
    q1.push_back(e);
  endtask

  task automatic drive2(input bit r, input bit v, input logic [15:0] d, input exp_t e);
    @(negedge clk);
    rst2            = r;
    if2.frame_valid = v;
    if2.frame_in    = d;
    q2.push_back(e);
  endtask

  task automatic stim1();
    logic [63:0] frm;
    logic        rdy;
    bit          v;
    logic [63:0] d;
    // Reset with an offer present: nothing may be captured.
    for (int i = 0; i < 3; i++) drive1(1'b0, 1'b1, FRM_B, '0);
    for (int k = 1; k <= 146; k++) begin
      v = 1'b0;
      d = '0;
      if (k == 1)                 begin v = 1'b1; d = FRM_B; end
      else if (k == 2)            begin v = 1'b1; d = FRM_A; end
      else if (k >= 3 && k <= 41) begin v = 1'b1; d = FRM_B; end
      else if (k == 125)          begin v = 1'b1; d = FRM_C; end
      if (k == 1)                  rdy = 1'b1;
      else if (k <= 39)            rdy = 1'b0;
      else if (k == 40)            rdy = 1'b1;
      else if (k <= 79)            rdy = 1'b0;
      else if (k <= 124)           rdy = 1'b1;
      else                         rdy = 1'b0;
      case ((k - 1) / 40)
        0:       frm = '0;
        1:       frm = FRM_A;
        default: frm = FRM_B;
      endcase
      drive1(1'b1, v, d, scan_exp(k, 5, 1, 40, 8, frm, rdy));
    end
    // Reset lands while row 5 is lit and frame C is pending.
    for (int i = 0; i < 2; i++) drive1(1'b0, 1'b1, FRM_C, '0);
    for (int k = 1; k <= 85; k++)
      drive1(1'b1, 1'b0, '0, scan_exp(k, 5, 1, 40, 8, '0, 1'b1));
  endtask

  task automatic stim2();
    logic [63:0] frm;
    logic        rdy;
    for (int i = 0; i < 2; i++) drive2(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 40; k++) begin
      rdy = (k == 1 || k >= 16);
      frm = (k <= 16) ? 64'd0 : FRM_S;
      drive2(1'b1, (k == 2), (k == 2) ? FRM_S[15:0] : 16'h0,
             scan_exp(k, 4, 2, 16, 4, frm, rdy));
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = '{rows: rows1, cols: cols1, done: done1, rdy: if1.frame_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL dut8x8 vec %0d: got rows=%h cols=%h done=%b rdy=%b, expected rows=%h cols=%h done=%b rdy=%b",
                 vectors, a.rows, a.cols, a.done, a.rdy, e.rows, e.cols, e.done, e.rdy);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = '{rows: {4'h0, rows2}, cols: {4'h0, cols2}, done: done2, rdy: if2.frame_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL dut4x4 vec %0d: got rows=%h cols=%h done=%b rdy=%b, expected rows=%h cols=%h done=%b rdy=%b",
                 vectors, a.rows, a.cols, a.done, a.rdy, e.rows, e.cols, e.done, e.rdy);
      end
    end
    if (end_req && !end_ack) begin
      vectors++;
      if (q1.size() + q2.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d expectations left, expected 0", q1.size() + q2.size());
      end
      end_ack = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    rst1            = 1'b0;
    rst2            = 1'b0;
    if1.frame_valid = 1'b0;
    if1.frame_in    = '0;
    if2.frame_valid = 1'b0;
    if2.frame_in    = '0;
    fork
      stim1();
      stim2();
    join
    repeat (2) @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
    if (!end_ack) begin
      $display("FAIL monitor: got no drain check, expected one");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Multiplexed row-scan driver for the 8x8 LED matrix, sitting directly downstream of the life engine inside `main`. Accepts whole generations as flat bit-vectors over a valid/ready handshake into a shadow buffer and scans the active buffer one row at a time onto `rows_out`/`columns_out`. Swaps shadow into active only at a frame boundary, so a frame is never torn. A blanking interval separates rows to suppress ghosting.

## Interface
- `ROWS`, 8, number of matrix rows (>= 2)
- `COLS`, 8, number of matrix columns (>= 1)
- `DWELL_CYCLES`, 4, clock cycles each row is lit (>= 1)
- `BLANK_CYCLES`, 1, clock cycles of all-off before each row (>= 1)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `frame_in`  in  ROWS*COLS  generation to display; bit `r*COLS+c` = cell (row r, col c), 1 = alive/lit
- `frame_valid`  in  1  `frame_in` is offered
- `frame_ready`  out  1  shadow buffer free; transfer occurs on edge where `frame_valid && frame_ready`
- `rows_out`  out  ROWS  one-hot active-high row select; all-zero while blanking
- `columns_out`  out  COLS  active-high column data for the selected row; all-zero while blanking
- `frame_done`  out  1  one-cycle pulse at each frame boundary

## Operation
- State: `active[ROWS*COLS]`, `shadow[ROWS*COLS]`, `pending`, `row` index, dwell/blank counter, FSM {BLANK, SHOW}.
- Reset (rst=0 at an edge): active=0, shadow=0, pending=0, row=0, counter=0, state=BLANK; outputs `rows_out`=0, `columns_out`=0, `frame_ready`=0, `frame_done`=0. Pending frame is discarded.
- BLANK: counter counts 0..BLANK_CYCLES-1; on last count -> SHOW, counter=0.
- SHOW: counter counts 0..DWELL_CYCLES-1; on last count -> BLANK, counter=0, row advances; row ROWS-1 wraps to 0 (frame boundary).
- Frame boundary: `frame_done`=1 for exactly one cycle; if `pending`, active<=shadow and pending<=0 on the same edge. If not pending, active is kept (last frame repeats).
- Handshake: transfer captures `frame_in` into shadow, sets pending. `frame_ready` is registered = !pending after that edge, so at most one frame outstanding; no accept while pending. Valid without ready is ignored (sender holds data).
- Simultaneous swap and offer: swap uses pending value before the edge; `frame_ready` is 0 in that cycle, so the offer is accepted no earlier than the next edge.
- Outputs are registers updated on the same edge as the FSM (no extra pipeline stage): in SHOW, `rows_out` = 1<<row, `columns_out` = active[row*COLS +: COLS]; in BLANK both zero.
- Counter width = $clog2 of max(DWELL_CYCLES, BLANK_CYCLES)+1; row index width = $clog2(ROWS).

## Timing
- Row period = BLANK_CYCLES+DWELL_CYCLES; frame period = ROWS*(BLANK_CYCLES+DWELL_CYCLES) (defaults: 5 and 40 cycles).
- Edge E1 = first edge with rst=1. `frame_ready`=1 after E1. Defaults: row r lit after edges E(1+5r)..E(4+5r), blank after E(5+5r); row 7 lit E36..E39; boundary at E40: `frame_done`=1 for the cycle after E40, swap visible when row 0 lights after E41.
- Accept-to-display latency: from accept until the next boundary plus BLANK_CYCLES; max one frame period + BLANK_CYCLES.
- `frame_ready` returns to 1 the cycle after the swapping edge.
- Reset mid-frame takes effect on the next edge regardless of state; no `frame_done` emitted for the interrupted frame.

## Test plan
- Reset: hold rst=0 for 3 edges with frame_valid=1 -> rows_out=0, columns_out=0, frame_ready=0, frame_done=0, nothing captured; frame_ready=1 after E1.
- Row sequence (defaults, active empty): rows_out = 0x01,0x02,...,0x80, each 4 cycles, separated by one 0x00 cycle; frame_done pulses every 40 cycles, first after E40.
- Load: row r of frame = r+1 offered at E2 -> accepted, frame_ready=0; first frame shows columns 0x00; after E40 swap, frame_ready=1; next frame row 3 shows columns_out=0x04 with rows_out=0x08.
- Backpressure: second frame (all 0xFF) held valid while pending -> not accepted until cycle after first swap; displayed the following frame; first frame shown intact for a full 40 cycles.
- Reset mid-frame during row 5 with a pending frame -> outputs zero next cycle, pending dropped, after release rows scan with columns_out=0x00, no spurious frame_done.
- Params ROWS=4, COLS=4, DWELL_CYCLES=2, BLANK_CYCLES=2 -> 16-cycle frame, rows_out 0x1,0x2,0x4,0x8 each 2 cycles after 2 blank cycles.
